// File: rtl/uart_rx_pkg.sv
// Shared constants for the oversampling UART receiver: FSM state codes,
// parity selects, legal prescale values and the majority-vote helper.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with three captures around the bit centre; bit_val is
// their majority and bit_end marks the last oversampling cycle of the bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] p,
  input  logic                      en,
  output logic                      bit_val,
  output logic                      bit_end
);

  logic [PRESCALE_WIDTH-1:0] ec;
  logic [PRESCALE_WIDTH-1:0] h;
  logic [2:0]                smp;

  assign h       = p >> 1;
  assign bit_end = en && (ec == p - PRESCALE_WIDTH'(1));
  assign bit_val = maj3(smp[0], smp[1], smp[2]);

  // Counter sits at 0 while disabled so the start-detect cycle is ec=0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ec  <= '0;
      smp <= '0;
    end else if (!en) begin
      ec <= '0;
    end else begin
      ec <= bit_end ? '0 : ec + PRESCALE_WIDTH'(1);
      if (ec == h - PRESCALE_WIDTH'(1)) smp[0] <= rx_in;
      if (ec == h)                      smp[1] <= rx_in;
      if (ec == h + PRESCALE_WIDTH'(1)) smp[2] <= rx_in;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first deserialize, optional parity and stop
// check; one-cycle DATA_VALID / PAR_ERR / STP_ERR strobes, all outputs registered.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [2:0]                state;
  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic [PRESCALE_WIDTH-1:0] p_cur;
  logic                      par_en_l;
  logic                      par_typ_l;
  logic                      par_flag;
  logic [BCW-1:0]            bc;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      start_det;
  logic                      smp_en;
  logic                      bit_val;
  logic                      bit_end;

  assign start_det = (state == ST_IDLE) && !RX_IN;
  assign smp_en    = (state != ST_IDLE) || start_det;
  // Latched prescale is not yet valid on the detect cycle itself.
  assign p_cur     = (state == ST_IDLE) ? PRESCALE : p_lat;

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_sampler (
    .CLK     (CLK),
    .RST     (RST),
    .rx_in   (RX_IN),
    .p       (p_cur),
    .en      (smp_en),
    .bit_val (bit_val),
    .bit_end (bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      p_lat      <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      par_flag   <= 1'b0;
      bc         <= '0;
      shreg      <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_det) begin
            state     <= ST_START;
            p_lat     <= PRESCALE;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            par_flag  <= 1'b0;
            bc        <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state <= bit_val ? ST_IDLE : ST_DATA;
            bc    <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bc    <= bc + BCW'(1);
            if (bc == BCW'(DATA_WIDTH - 1))
              state <= par_en_l ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            if (bit_val != ((^shreg) ^ (par_typ_l == PAR_ODD)))
              par_flag <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state   <= ST_IDLE;
            STP_ERR <= !bit_val;
            PAR_ERR <= par_flag;
            if (bit_val && !par_flag) begin
              DATA_VALID <= 1'b1;
              P_DATA     <= shreg;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, the expected
// strobe kind, cycle and P_DATA are queued and checked when a strobe appears.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  typedef struct {
    logic [2:0] kind;   // {valid, par_err, stp_err}
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  int         edge_n = 0;
  int         strobe_cnt = 0;
  int         c0;
  logic [7:0] last_good = 8'h00;
  logic [2:0] mon_kind;
  exp_t       mon_e;

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_n <= edge_n + 1;

  uart_rx #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest queued frame.
  always @(negedge CLK) begin
    mon_kind = {DATA_VALID === 1'b1, PAR_ERR === 1'b1, STP_ERR === 1'b1};
    if (mon_kind != 3'b000) begin
      strobe_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(mon_kind), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
        chk("strobe_cycle", edge_n, mon_e.cyc);
        chk("p_data", 32'(P_DATA), 32'(mon_e.data));
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit flip, input bit stop_v, input bit glitch);
    int   nb;
    bit   pbad;
    bit   good;
    exp_t e;
    logic v;
    nb   = pe ? 11 : 10;
    pbad = pe && flip;
    good = stop_v && !pbad;
    e.kind = {good, pbad, !stop_v};
    e.data = good ? d : last_good;
    if (good) last_good = d;
    e.cyc = edge_n + nb * p;
    sb.push_back(e);
    PRESCALE = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                v = 1'b0;
      else if (b <= 8)           v = d[b-1];
      else if (pe && b == 9)     v = (^d) ^ pt ^ flip;
      else                       v = stop_v;
      for (int c = 0; c < p; c++) begin
        RX_IN = (glitch && b >= 1 && b <= 8 && c == p / 2) ? ~v : v;
        @(negedge CLK);
      end
    end
  endtask

  task automatic drain(input string tag);
    RX_IN = 1'b1;
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge CLK);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    RST      = 1'b0;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = PAR_EVEN;
    PRESCALE = 6'(PRESCALE_8);

    repeat (8) begin
      @(negedge CLK);
      RX_IN = ~RX_IN;
    end
    chk("reset_outputs", 32'({P_DATA, DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
    RX_IN = 1'b1;
    RST   = 1'b1;
    idle(20);
    chk("idle_quiet", strobe_cnt, 0);

    send_frame(8'hA5, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain("drain_a5");

    send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain("drain_3c_good");
    send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    drain("drain_3c_parerr");

    send_frame(8'h0F, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0);
    drain("drain_0f_stperr");
    send_frame(8'h0F, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    drain("drain_0f_glitch");

    c0 = strobe_cnt;
    PRESCALE = 6'(PRESCALE_8);
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    idle(20);
    chk("false_start_quiet", strobe_cnt - c0, 0);
    send_frame(8'h81, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain("drain_81");

    send_frame(8'h66, PRESCALE_8, 1'b1, PAR_ODD, 1'b1, 1'b0, 1'b0);
    drain("drain_both_err");

    send_frame(8'h55, PRESCALE_32, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    send_frame(8'hAA, PRESCALE_32, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    drain("drain_b2b");

    c0 = strobe_cnt;
    PRESCALE = 6'(PRESCALE_32);
    RX_IN = 1'b0;
    repeat (100) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    RST   = 1'b1;
    last_good = 8'h00;
    idle(50);
    chk("rst_mid_quiet", strobe_cnt - c0, 0);
    chk("rst_mid_pdata", 32'(P_DATA), 32'(last_good));
    send_frame(8'hC3, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain("drain_c3");

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
